// File: rtl/ln_iter_sequencer_if.sv
// Handshake and mux-control bundle between the ln iteration sequencer and its datapath/requester.
// The master side is the sequencer itself; the slave side is whoever issues starts and acknowledges.
interface ln_iter_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             beg_fsm;
  logic             ack_fsm;
  logic [1:0]       MS;
  logic             load_reg;
  logic [CNT_W-1:0] iter_cnt;
  logic             busy;
  logic             ready;

  modport master (
    input  beg_fsm, ack_fsm,
    output MS, load_reg, iter_cnt, busy, ready
  );

  modport slave (
    output beg_fsm, ack_fsm,
    input  MS, load_reg, iter_cnt, busy, ready
  );
endinterface

// File: rtl/ln_iter_sequencer.sv
// Moore sequencer for the ln unit: loads D_0, runs ITER feedback passes on D_1, loads D_2,
// then holds ready until acknowledged. Outputs decode from state and counter registers only.
module ln_iter_sequencer #(
  parameter int ITER  = 24,
  parameter int CNT_W = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  ln_iter_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_INIT  = 3'd1,
    ITERATE    = 3'd2,
    LOAD_FINAL = 3'd3,
    DONE       = 3'd4
  } state_t;

  // Terminal index; ITER = 2^CNT_W gives all-ones, so the counter never wraps.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITER - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [1:0] ms_out;
  logic       load_out;
  logic       busy_out;
  logic       ready_out;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    unique case (state_reg)
      IDLE: begin
        if (bus.beg_fsm) state_next = LOAD_INIT;
      end
      LOAD_INIT: begin
        state_next = ITERATE;
      end
      ITERATE: begin
        if (cnt_reg == LAST_IDX) begin
          state_next = LOAD_FINAL;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      LOAD_FINAL: begin
        state_next = DONE;
      end
      DONE: begin
        // Ack wins over a simultaneous start; the start must be reissued in IDLE.
        if (bus.ack_fsm) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    ms_out    = 2'b00;
    load_out  = 1'b0;
    busy_out  = 1'b0;
    ready_out = 1'b0;
    unique case (state_reg)
      LOAD_INIT: begin
        load_out = 1'b1;
        busy_out = 1'b1;
      end
      ITERATE: begin
        ms_out   = 2'b01;
        load_out = 1'b1;
        busy_out = 1'b1;
      end
      LOAD_FINAL: begin
        ms_out   = 2'b10;
        load_out = 1'b1;
        busy_out = 1'b1;
      end
      DONE: begin
        ready_out = 1'b1;
      end
      default: begin
        ms_out = 2'b00;
      end
    endcase
  end

  assign bus.MS       = ms_out;
  assign bus.load_reg = load_out;
  assign bus.busy     = busy_out;
  assign bus.ready    = ready_out;
  // Counter is held at zero outside ITERATE, so it doubles as the index output.
  assign bus.iter_cnt = cnt_reg;

endmodule

// File: doc/ln_iter_sequencer.md
# ln_iter_sequencer

Control sequencer that drives the 2-bit select `MS` of the datapath 3:1 mux (`Mux_3x1`) and the load enable of the accumulator register fed by the mux output. It is the directly upstream control stage of that mux in the natural-logarithm unit. On a start pulse it first loads the initial operand (`D_0`), then runs `ITER` feedback iterations (`D_1`), then loads the final correction value (`D_2`). It then signals completion with a ready/acknowledge handshake. It also exposes the current iteration index for the shifter and constant-ROM addressing.

## Interface
- `ITER`, 24, number of feedback iterations; legal range 1..2^`CNT_W`.
- `CNT_W`, 5, width of the iteration counter.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `beg_fsm`  in  1  start request, sampled in IDLE only.
- `ack_fsm`  in  1  acknowledge of a finished result, sampled in DONE only.
- `MS`  out  2  mux select: 00 = `D_0` (initial), 01 = `D_1` (iterate), 10 = `D_2` (final); 11 is never driven.
- `load_reg`  out  1  load enable for the register capturing `D_out`.
- `iter_cnt`  out  `CNT_W`  current iteration index.
- `busy`  out  1  high from the first load through the final load.
- `ready`  out  1  result valid in the accumulator, held until acknowledged.

## Operation
- Moore FSM with five states: IDLE, LOAD_INIT, ITERATE, LOAD_FINAL, DONE. All outputs decode from the state register and the counter register only, so there is no combinational path from inputs to outputs.
- IDLE: `MS`=00, `load_reg`=0, `busy`=0, `ready`=0, `iter_cnt`=0.
  - `beg_fsm`=1 → LOAD_INIT; otherwise stay.
- LOAD_INIT: `MS`=00, `load_reg`=1, `busy`=1, counter cleared to 0. Next state is ITERATE unconditionally.
- ITERATE: `MS`=01, `load_reg`=1, `busy`=1, `iter_cnt`=current index.
  - If `iter_cnt` = `ITER`-1: → LOAD_FINAL and clear the counter to 0.
  - Otherwise: increment the counter and stay.
  - The state lasts exactly `ITER` cycles, and `iter_cnt` runs 0..`ITER`-1 in order.
- LOAD_FINAL: `MS`=10, `load_reg`=1, `busy`=1, `iter_cnt`=0. Next state is DONE unconditionally.
- DONE: `MS`=00, `load_reg`=0, `busy`=0, `ready`=1.
  - `ack_fsm`=1 → IDLE; otherwise stay indefinitely.
- Counter arithmetic is unsigned modulo 2^`CNT_W`. The terminal compare against `ITER`-1 guarantees the counter never wraps.
- `beg_fsm` is ignored in every state except IDLE. `ack_fsm` is ignored in every state except DONE.
- `beg_fsm` and `ack_fsm` high together in DONE: the ack wins → IDLE. The start is not registered, and the requester must reassert it in IDLE.
- `ITER`=1: ITERATE lasts one cycle with `iter_cnt`=0.

## Timing
- Reset (`RST`=0) forces IDLE asynchronously, regardless of state. This includes mid-ITERATE, in which case the partial result is abandoned.
  - Reset values: `MS`=00, `load_reg`=0, `iter_cnt`=0, `busy`=0, `ready`=0.
  - After `RST` deasserts, the first rising edge can already accept `beg_fsm`.
- Call the rising edge that samples `beg_fsm`=1 in IDLE edge E0.
  - Cycle after E0: LOAD_INIT.
  - Cycles E0+1 .. E0+`ITER`: ITERATE.
  - Cycle E0+`ITER`+1: LOAD_FINAL.
  - `ready` rises after edge E0+`ITER`+2.
- Start-to-ready latency is `ITER`+2 cycles. `busy` is high for exactly `ITER`+2 consecutive cycles and `load_reg` is high for the same cycles.
- `ready` falls on the edge that samples `ack_fsm`=1. The next start is accepted at the following edge, so the minimum turnaround is one IDLE cycle.
- In DONE, the accumulator value is stable because `load_reg`=0.

## Test plan
- Reset: `RST`=0 with random inputs → all outputs 0 and state IDLE. Release `RST`, hold `beg_fsm`=0 for 10 cycles → outputs unchanged.
- Nominal run, `ITER`=4: pulse `beg_fsm` for 1 cycle → `MS` sequence 00,01,01,01,01,10 with `load_reg`=1 for those 6 cycles and `iter_cnt` 0,0,1,2,3,0. `ready`=1 on cycle 7 and held until `ack_fsm`.
- Ignored inputs: `beg_fsm` held high through the whole run, and `ack_fsm` pulsed during ITERATE → the sequence is identical to the nominal run, and `ack_fsm` has no effect before DONE.
- Back-to-back: `ack_fsm` in DONE with `beg_fsm` held high → one IDLE cycle, then a second full 6-cycle run with identical outputs.
- Reset mid-operation: assert `RST` while `iter_cnt`=2 → all outputs 0 immediately, without waiting for a clock edge. A subsequent start runs the full `ITER`+2 sequence from `iter_cnt`=0.
- Boundary: `ITER`=1 → `MS` 00,01,10 with `iter_cnt`=0 throughout and `ready` after 3 cycles. `ITER`=32, `CNT_W`=5 → `iter_cnt` reaches 31 without wrapping, then LOAD_FINAL.
